// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution scheduler, its datapath and the bench:
// frame geometry, derived output sizes, coefficient type and scheduler states.
package conv_pkg;
    localparam int IMG_H      = 8;
    localparam int IMG_W      = 8;
    localparam int K          = 3;
    localparam int COEF_W_DEF = 8;
    localparam int OUT_H      = IMG_H - K + 1;
    localparam int OUT_W      = IMG_W - K + 1;
    localparam int N_OUT      = OUT_H * OUT_W;
    localparam int N_COEF     = K * K;

    typedef logic signed [COEF_W_DEF-1:0] coef_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } sched_state_e;
endpackage

// File: rtl/conv_kernel_bank.sv
// K*K signed coefficient register file with a single write port and a flattened
// read port (coefficient 0 in the LSBs). The caller gates i_we to the idle state.
module conv_kernel_bank
    import conv_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_we,
    input  logic [3:0]               i_addr,
    input  logic signed [COEF_W-1:0] i_data,
    output logic [N_COEF*COEF_W-1:0] o_kernel
);
    logic signed [COEF_W-1:0] r_coef [N_COEF];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_COEF; i++) begin
                r_coef[i] <= '0;
            end
        end else if (i_we && (i_addr < 4'(N_COEF))) begin
            r_coef[i_addr] <= i_data;
        end
    end

    for (genvar g = 0; g < N_COEF; g++) begin : g_flat
        assign o_kernel[g*COEF_W +: COEF_W] = r_coef[g];
    end
endmodule

// File: rtl/conv_window_scheduler.sv
// Issues the OUT_H x OUT_W window origins in raster order with a credit limit on windows
// in flight, maps in-order results to output buffer addresses and signals frame completion.
module conv_window_scheduler
    import conv_pkg::*;
#(
    parameter int COEF_W  = COEF_W_DEF,
    parameter int MAX_OUT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_st,
    input  logic                     kcfg_we,
    input  logic [3:0]               kcfg_addr,
    input  logic signed [COEF_W-1:0] kcfg_data,
    output logic [K*K*COEF_W-1:0]    kernel,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [2:0]               win_row,
    output logic [2:0]               win_col,
    input  logic                     res_valid,
    output logic                     wr_en,
    output logic [5:0]               wr_addr,
    output logic                     busy,
    output logic                     out_st,
    output logic                     start_err
);
    sched_state_e r_state;
    logic [2:0]   r_row;
    logic [2:0]   r_col;
    logic [5:0]   r_returned;
    logic [3:0]   r_outst;
    logic         r_start_err;

    logic w_active;
    logic w_accept;
    logic w_ret;
    logic w_last_win;
    logic w_last_ret;
    logic w_kwe;

    // Credit check uses the registered count, so a same-cycle return never lifts a stall early.
    assign w_active   = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign win_valid  = (r_state == S_ISSUE) && (r_outst < 4'(MAX_OUT));
    assign w_accept   = win_valid && win_ready;
    assign w_ret      = w_active && res_valid && (r_outst != 4'd0);
    assign w_last_win = (r_row == 3'(OUT_H-1)) && (r_col == 3'(OUT_W-1));
    assign w_last_ret = w_ret && (r_returned == 6'(N_OUT-1));
    assign w_kwe      = kcfg_we && (r_state == S_IDLE);

    assign win_row   = r_row;
    assign win_col   = r_col;
    assign wr_en     = w_ret;
    assign wr_addr   = r_returned;
    assign busy      = w_active;
    assign out_st    = (r_state == S_DONE);
    assign start_err = r_start_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_returned  <= '0;
            r_outst     <= '0;
            r_start_err <= 1'b0;
        end else begin
            r_start_err <= in_st && (r_state != S_IDLE);

            if (w_accept && !w_ret) begin
                r_outst <= r_outst + 4'd1;
            end else if (!w_accept && w_ret) begin
                r_outst <= r_outst - 4'd1;
            end

            if (w_ret) begin
                r_returned <= r_returned + 6'd1;
            end

            if (w_accept) begin
                if (r_col == 3'(OUT_W-1)) begin
                    r_col <= '0;
                    r_row <= (r_row == 3'(OUT_H-1)) ? 3'd0 : r_row + 3'd1;
                end else begin
                    r_col <= r_col + 3'd1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (in_st) begin
                        r_state    <= S_ISSUE;
                        r_row      <= '0;
                        r_col      <= '0;
                        r_returned <= '0;
                        r_outst    <= '0;
                    end
                end
                S_ISSUE: begin
                    if (w_last_ret) begin
                        r_state <= S_DONE;
                    end else if (w_accept && w_last_win) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_last_ret) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_returned <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    conv_kernel_bank #(
        .COEF_W (COEF_W)
    ) u_kernel_bank (
        .clk      (clk),
        .reset    (reset),
        .i_we     (w_kwe),
        .i_addr   (kcfg_addr),
        .i_data   (kcfg_data),
        .o_kernel (kernel)
    );
endmodule
